// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard/stall controller:
//   - opcode classes seen on the ID/EX boundary (OP_LOAD, OP_STORE)
//   - EX operand-forwarding select encoding (fwd_sel_e)
//   - memory-wait FSM state encoding (state_e)
//   - fwd_hit(): "producer stage can feed this source register" test
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;

  // Forwarding select as seen by the EX operand muxes.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,  // register file value (no hazard)
    FWD_MEMWB = 2'b01,  // result in MEM/WB
    FWD_EXMEM = 2'b10   // result in EX/MEM (youngest, wins)
  } fwd_sel_e;

  // Memory-wait FSM.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // A producer can forward to a source register only if it writes a
  // register, that register is not x0, and it matches the source.
  function automatic logic fwd_hit(
    input logic                  wen,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    return wen && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_fwd.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Pure combinational forwarding select for one EX source operand.
// Ports:
//   rs_i          source register read by the instruction leaving ID/EX
//   exmem_rsd_i   destination register held in EX/MEM
//   exmem_wen_i   EX/MEM instruction writes a register
//   memwb_rsd_i   destination register held in MEM/WB
//   memwb_wen_i   MEM/WB instruction writes a register
//   fwd_o         operand select (FWD_RF / FWD_EXMEM / FWD_MEMWB)
// EX/MEM is the younger producer, so it takes priority over MEM/WB.
// ---------------------------------------------------------------------------
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] exmem_rsd_i,
  input  logic                  exmem_wen_i,
  input  logic [REG_ADDR_W-1:0] memwb_rsd_i,
  input  logic                  memwb_wen_i,
  output logic [1:0]            fwd_o
);

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    fwd_o = FWD_RF;
    if (fwd_hit(exmem_wen_i, exmem_rsd_i, rs_i)) begin
      fwd_o = FWD_EXMEM;
    end else if (fwd_hit(memwb_wen_i, memwb_rsd_i, rs_i)) begin
      fwd_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Central hazard and stall controller for the 5-stage RISC-V pipeline.
//
// Parameters:
//   MEM_TIMEOUT  consecutive stalled memory-wait cycles that raise err_o
//   CNT_W        width of the wait counter and performance counters
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   id_rs1_i/id_rs2_i     source registers of the instruction in ID
//   idex_rs1_i/rs2_i      source registers leaving ID/EX (forwarding)
//   idex_rsd_i/op_i/valid destination, op class and valid leaving ID/EX
//   exmem_rsd_i/wen_i     EX/MEM producer
//   memwb_rsd_i/wen_i     MEM/WB producer
//   branch_taken_i        branch resolved taken in ID
//   dmem_req_i/ack_i      data-memory handshake of the MEM stage
//   fwd_a_o/fwd_b_o       EX operand selects (00 RF, 10 EX/MEM, 01 MEM/WB)
//   pc_stall_o            hold PC (load-use)
//   ifid_stall_o          hold IF/ID (load-use)
//   idex_bubble_o         force valid=0 into ID/EX (load-use or flush)
//   ifid_flush_o          clear IF/ID (taken branch)
//   all_stall_o           freeze every stage buffer (memory wait)
//   err_o                 sticky memory timeout
//
// Optional feature, macro HAZARD_PERF_EN: adds saturating performance
// counters lu_cnt_o (load-use stall cycles), mem_cnt_o (all_stall cycles)
// and flush_cnt_o (issued flushes).
//
// While reset is asserted every output is forced to 0, including the
// purely combinational ones, so the pipeline sees a quiet controller.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] idex_rs1_i,
  input  logic [REG_ADDR_W-1:0] idex_rs2_i,
  input  logic [REG_ADDR_W-1:0] idex_rsd_i,
  input  logic [2:0]            idex_op_i,
  input  logic                  idex_valid_i,
  input  logic [REG_ADDR_W-1:0] exmem_rsd_i,
  input  logic                  exmem_wen_i,
  input  logic [REG_ADDR_W-1:0] memwb_rsd_i,
  input  logic                  memwb_wen_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  pc_stall_o,
  output logic                  ifid_stall_o,
  output logic                  idex_bubble_o,
  output logic                  ifid_flush_o,
  output logic                  all_stall_o,
  output logic                  err_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      lu_cnt_o,
  output logic [CNT_W-1:0]      mem_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_nxt;
  logic             r_pending_flush;
  logic             w_pending_flush_nxt;
  logic             r_err;
  logic             w_err_nxt;

  // -------------------------------------------------------------------------
  // Combinational hazard detection
  // -------------------------------------------------------------------------
  logic       w_active;    // high outside reset; gates every output
  logic       w_all_stall;
  logic       w_lu;
  logic       w_flush;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_active = rst_i;

  fwd_unit u_fwd_a (
    .rs_i        (idex_rs1_i),
    .exmem_rsd_i (exmem_rsd_i),
    .exmem_wen_i (exmem_wen_i),
    .memwb_rsd_i (memwb_rsd_i),
    .memwb_wen_i (memwb_wen_i),
    .fwd_o       (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_i        (idex_rs2_i),
    .exmem_rsd_i (exmem_rsd_i),
    .exmem_wen_i (exmem_wen_i),
    .memwb_rsd_i (memwb_rsd_i),
    .memwb_wen_i (memwb_wen_i),
    .fwd_o       (w_fwd_b)
  );

  // A req acknowledged in the same cycle costs nothing.
  assign w_all_stall = w_active & dmem_req_i & ~dmem_ack_i;

  // The load in ID/EX has not produced its data yet; the dependent
  // instruction in ID must wait one cycle. The bubble we insert clears
  // idex_valid_i next cycle, so this condition ends on its own.
  assign w_lu = w_active & idex_valid_i & (idex_op_i == OP_LOAD) &
                (idex_rsd_i != '0) &
                ((idex_rsd_i == id_rs1_i) | (idex_rsd_i == id_rs2_i));

  // A taken branch seen during a memory freeze is remembered and issued in
  // the first unfrozen cycle.
  assign w_flush = w_active & ~w_all_stall & (branch_taken_i | r_pending_flush);

  // The frozen buffers ignore hold/bubble/flush, so all_stall masks them.
  // A flush discards the dependent instruction, so it wins over load-use.
  assign all_stall_o   = w_all_stall;
  assign ifid_flush_o  = w_flush;
  assign pc_stall_o    = ~w_all_stall & w_lu & ~w_flush;
  assign ifid_stall_o  = ~w_all_stall & w_lu & ~w_flush;
  assign idex_bubble_o = ~w_all_stall & (w_lu | w_flush);
  assign fwd_a_o       = w_active ? w_fwd_a : FWD_RF;
  assign fwd_b_o       = w_active ? w_fwd_b : FWD_RF;
  assign err_o         = r_err;

  // -------------------------------------------------------------------------
  // Memory-wait FSM, wait counter, pending flush, sticky error
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt         = r_state;
    w_wait_cnt_nxt      = r_wait_cnt;
    w_err_nxt           = r_err;
    w_pending_flush_nxt = w_all_stall & (r_pending_flush | branch_taken_i);

    unique case (r_state)
      RUN: begin
        w_wait_cnt_nxt = '0;
        if (w_all_stall) begin
          w_state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (w_all_stall) begin
          // Count stalled wait cycles, holding at the timeout value.
          if (r_wait_cnt != TIMEOUT_C) begin
            w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
          end
          if (w_wait_cnt_nxt == TIMEOUT_C) begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of the others, independent of order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state         <= RUN;
      r_wait_cnt      <= '0;
      r_pending_flush <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_wait_cnt      <= w_wait_cnt_nxt;
      r_pending_flush <= w_pending_flush_nxt;
      r_err           <= w_err_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters (saturate at all-ones)
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_mem_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lu_cnt    <= '0;
      r_mem_cnt   <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_lu_cnt    <= sat_inc(r_lu_cnt, pc_stall_o);
      r_mem_cnt   <= sat_inc(r_mem_cnt, w_all_stall);
      r_flush_cnt <= sat_inc(r_flush_cnt, w_flush);
    end
  end

  assign lu_cnt_o    = r_lu_cnt;
  assign mem_cnt_o   = r_mem_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Scoreboard bench: the stimulus process drives one input vector per cycle
// and pushes the reference model's expected outputs; a monitor on the
// falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 16;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rsd, exmem_rsd, memwb_rsd;
  logic [2:0] idex_op;
  logic       idex_valid, exmem_wen, memwb_wen, branch_taken, dmem_req, dmem_ack;
  logic [1:0] fwd_a, fwd_b;
  logic       pc_stall, ifid_stall, idex_bubble, ifid_flush, all_stall, err;
`ifdef HAZARD_PERF_EN
  logic [TB_CNT_W-1:0] lu_cnt, mem_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .idex_rs1_i     (idex_rs1),
    .idex_rs2_i     (idex_rs2),
    .idex_rsd_i     (idex_rsd),
    .idex_op_i      (idex_op),
    .idex_valid_i   (idex_valid),
    .exmem_rsd_i    (exmem_rsd),
    .exmem_wen_i    (exmem_wen),
    .memwb_rsd_i    (memwb_rsd),
    .memwb_wen_i    (memwb_wen),
    .branch_taken_i (branch_taken),
    .dmem_req_i     (dmem_req),
    .dmem_ack_i     (dmem_ack),
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
    .pc_stall_o     (pc_stall),
    .ifid_stall_o   (ifid_stall),
    .idex_bubble_o  (idex_bubble),
    .ifid_flush_o   (ifid_flush),
    .all_stall_o    (all_stall),
    .err_o          (err)
`ifdef HAZARD_PERF_EN
    ,
    .lu_cnt_o       (lu_cnt),
    .mem_cnt_o      (mem_cnt),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  typedef struct {
    logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rsd, ex_rd, mw_rd;
    logic [2:0] op;
    logic       valid, ex_wen, mw_wen, br, req, ack;
  } stim_t;

  typedef struct {
    logic [1:0] fwd_a, fwd_b;
    logic       pc_stall, ifid_stall, bubble, flush, all_stall, err;
    int         lu_cnt, mem_cnt, flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, expressed in terms of the observable behaviour.
  logic m_pending;   // taken branch seen during a freeze, not yet flushed
  logic m_err;
  int   m_stall_run; // consecutive cycles with the memory freeze active
  int   m_lu_cnt, m_mem_cnt, m_flush_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input stim_t s, input logic [4:0] rs);
    if (s.ex_wen && s.ex_rd != 0 && s.ex_rd == rs) return 2'b10;
    if (s.mw_wen && s.mw_rd != 0 && s.mw_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_pending   = 1'b0;
    m_err       = 1'b0;
    m_stall_run = 0;
    m_lu_cnt    = 0;
    m_mem_cnt   = 0;
    m_flush_cnt = 0;
  endtask

  task automatic model_step(input stim_t s);
    exp_t e;
    logic stall, lu, fl;
    stall = s.req && !s.ack;
    lu    = s.valid && s.op == OP_LOAD && s.idex_rsd != 0 &&
            (s.idex_rsd == s.id_rs1 || s.idex_rsd == s.id_rs2);
    fl    = !stall && (s.br || m_pending);
    e.fwd_a      = fwd_ref(s, s.idex_rs1);
    e.fwd_b      = fwd_ref(s, s.idex_rs2);
    e.all_stall  = stall;
    e.flush      = fl;
    e.pc_stall   = !stall && lu && !fl;
    e.ifid_stall = !stall && lu && !fl;
    e.bubble     = !stall && (lu || fl);
    e.err        = m_err;
    e.lu_cnt     = m_lu_cnt;
    e.mem_cnt    = m_mem_cnt;
    e.flush_cnt  = m_flush_cnt;
    exp_q.push_back(e);
    // Effects visible from the next cycle on.
    m_pending   = stall && (m_pending || s.br);
    m_stall_run = stall ? m_stall_run + 1 : 0;
    // The first frozen cycle enters the wait; the timeout counts wait
    // cycles after it.
    if (m_stall_run > TB_TIMEOUT) m_err = 1'b1;
    if (e.pc_stall && m_lu_cnt < CNT_MAX)  m_lu_cnt++;
    if (stall && m_mem_cnt < CNT_MAX)      m_mem_cnt++;
    if (fl && m_flush_cnt < CNT_MAX)       m_flush_cnt++;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.id_rs1 = '0; s.id_rs2 = '0; s.idex_rs1 = '0; s.idex_rs2 = '0;
    s.idex_rsd = '0; s.ex_rd = '0; s.mw_rd = '0; s.op = '0;
    s.valid = 1'b0; s.ex_wen = 1'b0; s.mw_wen = 1'b0;
    s.br = 1'b0; s.req = 1'b0; s.ack = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; idex_rs1 = s.idex_rs1;
    idex_rs2 = s.idex_rs2; idex_rsd = s.idex_rsd; idex_op = s.op;
    idex_valid = s.valid; exmem_rsd = s.ex_rd; exmem_wen = s.ex_wen;
    memwb_rsd = s.mw_rd; memwb_wen = s.mw_wen; branch_taken = s.br;
    dmem_req = s.req; dmem_ack = s.ack;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    model_step(s);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_rs1   = 5'($urandom_range(0, 3));
    s.id_rs2   = 5'($urandom_range(0, 3));
    s.idex_rs1 = 5'($urandom_range(0, 3));
    s.idex_rs2 = 5'($urandom_range(0, 3));
    s.idex_rsd = 5'($urandom_range(0, 3));
    s.ex_rd    = 5'($urandom_range(0, 3));
    s.mw_rd    = 5'($urandom_range(0, 3));
    s.op       = ($urandom_range(0, 1) == 1) ? OP_LOAD : 3'($urandom_range(0, 7));
    s.valid    = 1'($urandom_range(0, 1));
    s.ex_wen   = 1'($urandom_range(0, 1));
    s.mw_wen   = 1'($urandom_range(0, 1));
    s.br       = ($urandom_range(0, 5) == 0);
    s.req      = ($urandom_range(0, 9) < 4);
    s.ack      = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Direct check of the quiet-output state while reset is held.
  task automatic check_all_zero(input string tag);
    check({tag, "_fwd_a"},       32'(fwd_a), 0);
    check({tag, "_fwd_b"},       32'(fwd_b), 0);
    check({tag, "_pc_stall"},    32'(pc_stall), 0);
    check({tag, "_ifid_stall"},  32'(ifid_stall), 0);
    check({tag, "_bubble"},      32'(idex_bubble), 0);
    check({tag, "_flush"},       32'(ifid_flush), 0);
    check({tag, "_all_stall"},   32'(all_stall), 0);
    check({tag, "_err"},         32'(err), 0);
`ifdef HAZARD_PERF_EN
    check({tag, "_lu_cnt"},      32'(lu_cnt), 0);
    check({tag, "_mem_cnt"},     32'(mem_cnt), 0);
    check({tag, "_flush_cnt"},   32'(flush_cnt), 0);
`endif
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("fwd_a",       32'(fwd_a),       32'(mon_e.fwd_a));
      check("fwd_b",       32'(fwd_b),       32'(mon_e.fwd_b));
      check("pc_stall",    32'(pc_stall),    32'(mon_e.pc_stall));
      check("ifid_stall",  32'(ifid_stall),  32'(mon_e.ifid_stall));
      check("idex_bubble", 32'(idex_bubble), 32'(mon_e.bubble));
      check("ifid_flush",  32'(ifid_flush),  32'(mon_e.flush));
      check("all_stall",   32'(all_stall),   32'(mon_e.all_stall));
      check("err",         32'(err),         32'(mon_e.err));
`ifdef HAZARD_PERF_EN
      check("lu_cnt",      32'(lu_cnt),      32'(mon_e.lu_cnt));
      check("mem_cnt",     32'(mem_cnt),     32'(mon_e.mem_cnt));
      check("flush_cnt",   32'(flush_cnt),   32'(mon_e.flush_cnt));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    model_reset();
    // Reset with a pending memory request: outputs must stay quiet.
    rst_i = 1'b0;
    s = idle();
    s.req = 1'b1;
    apply(s);
    #12;
    check_all_zero("reset");
    s.req = 1'b0;
    apply(s);
    @(negedge clk);
    rst_i = 1'b1;

    // Forwarding: EX/MEM priority, then MEM/WB, then x0 never forwards.
    s = idle();
    s.ex_rd = 5; s.ex_wen = 1; s.mw_rd = 5; s.mw_wen = 1; s.idex_rs1 = 5;
    drive(s);
    s.ex_wen = 0;
    drive(s);
    s.ex_wen = 1; s.ex_rd = 0; s.mw_rd = 0; s.idex_rs1 = 0;
    drive(s);
    s = idle();
    s.mw_rd = 9; s.mw_wen = 1; s.idex_rs2 = 9; s.ex_rd = 3; s.ex_wen = 1;
    drive(s);

    // Load-use for one cycle, self-terminated by the bubble.
    s = idle();
    s.op = OP_LOAD; s.idex_rsd = 7; s.valid = 1; s.id_rs2 = 7;
    drive(s);
    s.valid = 0;
    drive(s);

    // Memory wait: three stalled cycles, ack; twice, so the counter must clear.
    for (int r = 0; r < 2; r++) begin
      s = idle();
      s.req = 1;
      repeat (3) drive(s);
      s.ack = 1;
      drive(s);
      drive(idle());
    end

    // Deferred flush: branch during freeze, issued in first unfrozen cycle.
    s = idle();
    s.req = 1; s.br = 1;
    drive(s);
    s.br = 0;
    drive(s);
    drive(idle());
    drive(idle());

    // Load-use masked by a freeze, then flush overriding load-use.
    s = idle();
    s.op = OP_LOAD; s.idex_rsd = 4; s.valid = 1; s.id_rs1 = 4; s.req = 1;
    drive(s);
    s.req = 0; s.br = 1;
    drive(s);
    drive(idle());

    // Randomised traffic.
    for (int i = 0; i < 500; i++) drive(rand_stim());
    drive(idle());

    // Timeout: request held without ack; err rises and stays.
    s = idle();
    s.req = 1;
    repeat (TB_TIMEOUT + 4) drive(s);

    // Asynchronous reset in the middle of the wait.
    #6;
    rst_i = 1'b0;
    #1;
    check_all_zero("midwait_reset");
    @(posedge clk);
    #2;
    check_all_zero("held_reset");
    @(negedge clk);
    model_reset();
    rst_i = 1'b1;
    apply(idle());

    for (int i = 0; i < 100; i++) drive(rand_stim());
    drive(idle());
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
